alu_arbiter: RTL and testbench
==============================

Name: alu_arbiter

Overview:
- Shares the single combinational ALU between NUM_REQ requesters, e.g. the integer pipe and the address/branch unit.
- Each requester presents operands and a 3-bit ALU control code over a valid/ready handshake.
- The arbiter picks one requester round-robin, registers its operands, drives the ALU for one cycle, captures out/zero, then returns the result with the requester ID over a valid/ready response channel.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- ID_W, 1, response ID width; must equal max(1, clog2(NUM_REQ)).
- DATA_W, 32, operand/result width; fixed to ALU width.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  NUM_REQ  per-requester request valid.
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
- req_in1  input  NUM_REQ*DATA_W  packed operand 1, requester i at [i*DATA_W +: DATA_W].
- req_in2  input  NUM_REQ*DATA_W  packed operand 2.
- req_control  input  NUM_REQ*3  packed ALU control code.
- alu_in1  output  DATA_W  to ALU in1.
- alu_in2  output  DATA_W  to ALU in2.
- alu_control  output  3  to ALU control.
- alu_out  input  DATA_W  from ALU out.
- alu_zero  input  1  from ALU zero.
- rsp_valid  output  1  result valid.
- rsp_ready  input  1  consumer accepts result.
- rsp_id  output  ID_W  index of the requester that issued the operation.
- rsp_out  output  DATA_W  captured ALU result.
- rsp_zero  output  1  captured ALU zero flag.

Behaviour:
- Reset (asynchronous, active-high) drives:
  - state=IDLE, rr_ptr=0
  - req_ready=0, rsp_valid=0, rsp_id=0, rsp_out=0, rsp_zero=0
  - alu_in1=0, alu_in2=0, alu_control=3'b000
- Reset mid-operation discards any in-flight op and pending response. No partial response is emitted after reset deasserts.
- FSM states: IDLE, ISSUE, RESP.
- IDLE:
  - grant = first set req_valid bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - req_ready = grant, combinational, only in IDLE.
  - On handshake: latch in1/in2/control/id into operand registers; rr_ptr <= (granted index+1) mod NUM_REQ; go to ISSUE.
  - With no valid requests, stay in IDLE and leave rr_ptr unchanged.
- ISSUE:
  - Operand registers drive alu_in1/alu_in2/alu_control (registered, glitch-free).
  - End of cycle: rsp_out<=alu_out, rsp_zero<=alu_zero, rsp_id<=latched id, rsp_valid<=1; go to RESP.
- RESP:
  - Hold rsp_* stable while rsp_valid && !rsp_ready.
  - On rsp_ready: rsp_valid<=0, go to IDLE.
  - rsp_out/rsp_zero/rsp_id keep their last value after the handshake.
- Latency and throughput:
  - Request handshake at cycle N gives rsp_valid high at cycle N+2.
  - Peak throughput is 1 op per 3 cycles.
- ALU inputs hold their last operands outside ISSUE; no toggling when idle.
- Requesters must hold valid and payload stable until ready. The arbiter never drops a presented request.
- Unsupported control codes are forwarded unchanged. The result is whatever the ALU returns: out=0, zero=1.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NUM_REQ-1,0. No requester waits more than NUM_REQ-1 other grants.
- rsp_ready held high in IDLE/ISSUE has no effect.

Optional Feature:
- Macro: ALU_ARB_PERF_EN.
- Defined:
  - Adds output perf_grants, NUM_REQ*16 bits: per-requester saturating grant counters.
  - Each counter increments on its requester's handshake, saturates at 16'hFFFF, and clears on reset.
  - Adds output perf_stall, 16 bits, saturating: counts cycles in RESP with !rsp_ready.
- Undefined: ports and logic are absent; the rest of the behaviour is identical.

Decomposition:
- Package alu_arb_pkg:
  - ALU control constants: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_AND=3'b010, ALU_OR=3'b011.
  - FSM state encoding: IDLE=2'd0, ISSUE=2'd1, RESP=2'd2.
  - DATA_W default.
- Sub-module rr_pick:
  - Purely combinational round-robin priority picker.
  - Inputs: req vector, rr_ptr. Outputs: one-hot grant, binary index, any.
  - Instantiated once.

Test Plan:
- Single op: after reset, req0 valid, in1=5, in2=7, control=000, rsp_ready=1 -> req_ready[0] high in IDLE; rsp_valid 2 cycles after handshake with rsp_out=12, rsp_zero=0, rsp_id=0.
- Subtract to zero: req1 in1=32'h1234, in2=32'h1234, control=001 -> rsp_out=0, rsp_zero=1, rsp_id=1.
- Round-robin: both requesters valid continuously, 6 ops, rsp_ready=1 -> rsp_id sequence 0,1,0,1,0,1; req_ready never has two bits set.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid, with in1=32'hF0F0, in2=32'h0FF0, control=011 -> rsp_out=32'hFFF0 held stable and req_ready=0 throughout; IDLE is re-entered the cycle after rsp_ready rises.
- Reset mid-op: assert reset during ISSUE -> all outputs 0 immediately; no rsp_valid after release until a new request is accepted; next grant goes to requester 0.
- Invalid control 3'b111 with in1=in2=32'hFFFFFFFF -> rsp_out=0, rsp_zero=1. With ALU_ARB_PERF_EN, perf_grants for that requester increments by 1.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared constants for the ALU arbiter: control codes, FSM encoding, default width.
package alu_arb_pkg;

    localparam int DATA_W_DEF = 32;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] RESP  = 2'd2;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above ptr, wrapping; zero latency.
// Purely combinational, no backpressure of its own.
module rr_pick
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    idx,
    output logic               any
);

    int cand;

    always_comb begin
        gnt  = '0;
        idx  = '0;
        any  = 1'b0;
        cand = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = (int'(ptr) + k) % NUM_REQ;
            if (!any && req[cand]) begin
                any       = 1'b1;
                gnt[cand] = 1'b1;
                idx       = ID_W'(cand);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU among NUM_REQ requesters, round-robin; optional ALU_ARB_PERF_EN counters.
// Latency: request handshake at cycle N -> rsp_valid at N+2; one op per 3 cycles.
// Backpressure: response held until rsp_ready; no request accepted while an op is in flight.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ID_W    = 1,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*DATA_W-1:0] req_in1,
    input  logic [NUM_REQ*DATA_W-1:0] req_in2,
    input  logic [NUM_REQ*3-1:0]      req_control,
    output logic [DATA_W-1:0]         alu_in1,
    output logic [DATA_W-1:0]         alu_in2,
    output logic [2:0]                alu_control,
    input  logic [DATA_W-1:0]         alu_out,
    input  logic                      alu_zero,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [ID_W-1:0]           rsp_id,
    output logic [DATA_W-1:0]         rsp_out,
    output logic                      rsp_zero
`ifdef ALU_ARB_PERF_EN
    ,
    output logic [NUM_REQ*16-1:0]     perf_grants,
    output logic [15:0]               perf_stall
`endif
);

    logic [1:0]         state;
    logic [ID_W-1:0]    rr_ptr;
    logic [ID_W-1:0]    op_id;
    logic [ID_W-1:0]    gnt_idx;
    logic [ID_W-1:0]    ptr_nxt;
    logic [NUM_REQ-1:0] gnt;
    logic               gnt_any;
    logic               req_fire;
    logic [DATA_W-1:0]  sel_in1;
    logic [DATA_W-1:0]  sel_in2;
    logic [2:0]         sel_ctrl;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req (req_valid),
        .ptr (rr_ptr),
        .gnt (gnt),
        .idx (gnt_idx),
        .any (gnt_any)
    );

    assign req_ready = (state == IDLE && !reset) ? gnt : '0;
    assign req_fire  = (state == IDLE) && gnt_any && !reset;
    assign ptr_nxt   = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    // One-hot grant turns the payload select into a plain AND-OR mux.
    always_comb begin
        sel_in1  = '0;
        sel_in2  = '0;
        sel_ctrl = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                sel_in1  = sel_in1  | req_in1[i*DATA_W +: DATA_W];
                sel_in2  = sel_in2  | req_in2[i*DATA_W +: DATA_W];
                sel_ctrl = sel_ctrl | req_control[i*3 +: 3];
            end
        end
    end

    // The ALU inputs are the operand registers, so they only change on acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            op_id       <= '0;
            alu_in1     <= '0;
            alu_in2     <= '0;
            alu_control <= 3'b000;
            rsp_valid   <= 1'b0;
            rsp_id      <= '0;
            rsp_out     <= '0;
            rsp_zero    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        alu_in1     <= sel_in1;
                        alu_in2     <= sel_in2;
                        alu_control <= sel_ctrl;
                        op_id       <= gnt_idx;
                        rr_ptr      <= ptr_nxt;
                        state       <= ISSUE;
                    end
                end
                ISSUE: begin
                    rsp_out   <= alu_out;
                    rsp_zero  <= alu_zero;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ARB_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_grants <= '0;
            perf_stall  <= '0;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (req_fire && gnt[i])
                    perf_grants[i*16 +: 16] <= sat_inc(perf_grants[i*16 +: 16]);
            end
            if (state == RESP && !rsp_ready)
                perf_stall <= sat_inc(perf_stall);
        end
    end
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU; honours ALU_ARB_PERF_EN when defined.
module tb_alu_arbiter;
    import alu_arb_pkg::*;

    localparam int NUM_REQ = 2;
    localparam int ID_W    = 1;
    localparam int DATA_W  = 32;

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DATA_W-1:0] req_in1;
    logic [NUM_REQ*DATA_W-1:0] req_in2;
    logic [NUM_REQ*3-1:0]      req_control;
    logic [DATA_W-1:0]         alu_in1;
    logic [DATA_W-1:0]         alu_in2;
    logic [2:0]                alu_control;
    logic [DATA_W-1:0]         alu_out;
    logic                      alu_zero;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_out;
    logic                      rsp_zero;
`ifdef ALU_ARB_PERF_EN
    logic [NUM_REQ*16-1:0]     perf_grants;
    logic [15:0]               perf_stall;
`endif

    int   tests_run    = 0;
    int   tests_failed = 0;
    logic multi_gnt    = 1'b0;

    always #5 clk = ~clk;

    alu_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W),
        .DATA_W  (DATA_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_in1     (req_in1),
        .req_in2     (req_in2),
        .req_control (req_control),
        .alu_in1     (alu_in1),
        .alu_in2     (alu_in2),
        .alu_control (alu_control),
        .alu_out     (alu_out),
        .alu_zero    (alu_zero),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_id      (rsp_id),
        .rsp_out     (rsp_out),
        .rsp_zero    (rsp_zero)
`ifdef ALU_ARB_PERF_EN
        ,
        .perf_grants (perf_grants),
        .perf_stall  (perf_stall)
`endif
    );

    // Reference ALU: unsupported codes give out=0, zero=1.
    always_comb begin
        alu_out = '0;
        case (alu_control)
            ALU_ADD: alu_out = alu_in1 + alu_in2;
            ALU_SUB: alu_out = alu_in1 - alu_in2;
            ALU_AND: alu_out = alu_in1 & alu_in2;
            ALU_OR:  alu_out = alu_in1 | alu_in2;
            default: alu_out = '0;
        endcase
        alu_zero = (alu_out == '0);
    end

    always @(negedge clk)
        if ($countones(req_ready) > 1) multi_gnt = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                           input logic [2:0] c);
        req_in1[i*DATA_W +: DATA_W] = a;
        req_in2[i*DATA_W +: DATA_W] = b;
        req_control[i*3 +: 3]       = c;
    endtask

    // Present a request alone and hold it until the arbiter takes it.
    task automatic send(input string tag, input int i);
        int n;
        n = 0;
        req_valid[i] = 1'b1;
        @(negedge clk);
        while (!req_ready[i] && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_grant"}, 32'(req_ready[i]), 32'd1);
        @(posedge clk);
        #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic [31:0] out, input logic z,
                              input logic id);
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_vld"},  32'(rsp_valid), 32'd1);
        check_eq({tag, "_out"},  rsp_out, out);
        check_eq({tag, "_zero"}, 32'(rsp_zero), 32'(z));
        check_eq({tag, "_id"},   32'(rsp_id), 32'(id));
    endtask

    initial begin
        reset       = 1'b1;
        req_valid   = '0;
        req_in1     = '0;
        req_in2     = '0;
        req_control = '0;
        rsp_ready   = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req_ready", 32'(req_ready), 32'd0);
        check_eq("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("rst_rsp_out",   rsp_out, 32'd0);
        check_eq("rst_rsp_id",    32'(rsp_id), 32'd0);
        check_eq("rst_alu_in1",   alu_in1, 32'd0);
        check_eq("rst_alu_ctrl",  32'(alu_control), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Single add with exact latency.
        set_req(0, 32'd5, 32'd7, ALU_ADD);
        req_valid[0] = 1'b1;
        @(negedge clk);
        check_eq("t1_ready", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        check_eq("t1_issue_vld", 32'(rsp_valid), 32'd0);
        check_eq("t1_alu_in1",   alu_in1, 32'd5);
        check_eq("t1_alu_in2",   alu_in2, 32'd7);
        @(negedge clk);
        check_eq("t1_vld",  32'(rsp_valid), 32'd1);
        check_eq("t1_out",  rsp_out, 32'd12);
        check_eq("t1_zero", 32'(rsp_zero), 32'd0);
        check_eq("t1_id",   32'(rsp_id), 32'd0);
        @(posedge clk);
        #1;

        // Subtract to zero from requester 1.
        set_req(1, 32'h1234, 32'h1234, ALU_SUB);
        send("t2", 1);
        expect_rsp("t2", 32'd0, 1'b1, 1'b1);
        @(posedge clk);
        #1;

        // Both requesters continuously valid: ids alternate from 0.
        set_req(0, 32'd10, 32'd1, ALU_ADD);
        set_req(1, 32'd20, 32'd3, ALU_SUB);
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            expect_rsp($sformatf("rr%0d", k), (k % 2 == 1) ? 32'd17 : 32'd11,
                       1'b0, 1'(k % 2));
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        check_eq("rr_onehot", 32'(multi_gnt), 32'd0);

        // Backpressure: response held, nothing granted, IDLE right after release.
        set_req(0, 32'hF0F0, 32'h0FF0, ALU_OR);
        rsp_ready = 1'b0;
        send("bp", 0);
        set_req(1, 32'h55, 32'h11, ALU_SUB);
        req_valid[1] = 1'b1;
        expect_rsp("bp", 32'hFFF0, 1'b0, 1'b0);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check_eq($sformatf("bp_hold_vld%0d", j), 32'(rsp_valid), 32'd1);
            check_eq($sformatf("bp_hold_out%0d", j), rsp_out, 32'hFFF0);
            check_eq($sformatf("bp_hold_rdy%0d", j), 32'(req_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        check_eq("bp_last_vld", 32'(rsp_valid), 32'd1);
        @(negedge clk);
        check_eq("bp_idle_ready", 32'(req_ready), 32'h2);
        check_eq("bp_keep_out",   rsp_out, 32'hFFF0);
`ifdef ALU_ARB_PERF_EN
        check_eq("perf_stall", 32'(perf_stall), 32'd6);
`endif
        @(posedge clk);
        #1;
        req_valid = '0;
        expect_rsp("bp_next", 32'h44, 1'b0, 1'b1);
        @(posedge clk);
        #1;

        // Reset while an op sits in ISSUE.
        set_req(0, 32'd3, 32'd6, ALU_AND);
        send("mid", 0);
`ifdef ALU_ARB_PERF_EN
        check_eq("perf_g0_pre", 32'(perf_grants[15:0]),  32'd6);
        check_eq("perf_g1_pre", 32'(perf_grants[31:16]), 32'd5);
`endif
        reset = 1'b1;
        #1;
        check_eq("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        check_eq("mid_rsp_out",   rsp_out, 32'd0);
        check_eq("mid_rsp_id",    32'(rsp_id), 32'd0);
        check_eq("mid_alu_in1",   alu_in1, 32'd0);
        check_eq("mid_alu_ctrl",  32'(alu_control), 32'd0);
        check_eq("mid_req_ready", 32'(req_ready), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            check_eq($sformatf("mid_quiet%0d", j), 32'(rsp_valid), 32'd0);
        end

        // Unsupported control code after reset; grant must restart at 0.
        set_req(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b111);
        set_req(1, 32'd1, 32'd1, ALU_ADD);
        @(posedge clk);
        #1;
        req_valid = 2'b11;
        @(negedge clk);
        check_eq("rst_grant0", 32'(req_ready), 32'h1);
        @(posedge clk);
        #1;
        req_valid = '0;
        expect_rsp("inv", 32'd0, 1'b1, 1'b0);
        check_eq("inv_ctrl", 32'(alu_control), 32'h7);
`ifdef ALU_ARB_PERF_EN
        check_eq("perf_g0_post", 32'(perf_grants[15:0]),  32'd1);
        check_eq("perf_g1_post", 32'(perf_grants[31:16]), 32'd0);
`endif
        @(posedge clk);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
